// File: rtl/i2c_target_wr.sv
// ---------------------------------------------------------------------------
// i2c_target_wr
//
// Write-only I2C target for the dice design. Oversamples SCL/SDA in the
// system clock domain, decodes START/STOP, and matches a 7-bit device
// address. A matching write is ACKed. The first byte after the address
// loads an 8-bit register pointer. Every following byte produces one
// register-write strobe, and the pointer advances after each byte. Read
// requests and foreign addresses are NAKed and then ignored until the next
// START or STOP.
//
// Ports:
//   clk      system clock (>= 8x SCL rate)
//   rst      asynchronous reset, active-high
//   scl_in   raw SCL from pad
//   sda_in   raw SDA from pad
//   sda_out  constant 0 (open-drain emulation)
//   sda_oe   1 = pull SDA low (ACK)
//   wr_valid one-cycle register-write strobe
//   wr_addr  register address for the current strobe
//   wr_data  register data for the current strobe
//   busy     high from START until STOP
// ---------------------------------------------------------------------------
module i2c_target_wr #(
    parameter logic [6:0] DEV_ADDR    = 7'h70,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_out,
    output logic       sda_oe,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ADDR     = 3'd1;
    localparam logic [2:0] S_ADDR_ACK = 3'd2;
    localparam logic [2:0] S_SUB      = 3'd3;
    localparam logic [2:0] S_SUB_ACK  = 3'd4;
    localparam logic [2:0] S_DATA     = 3'd5;
    localparam logic [2:0] S_DATA_ACK = 3'd6;
    localparam logic [2:0] S_IGNORE   = 3'd7;

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_hist_q, sda_hist_q;

    logic [2:0] state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] cnt_q, cnt_d;
    logic       full_q, full_d;
    logic [7:0] ptr_q, ptr_d;
    logic       sda_oe_q, sda_oe_d;
    logic       wr_valid_q, wr_valid_d;
    logic [7:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       busy_q, busy_d;

    logic scl_s, sda_s;
    logic scl_rise, scl_fall, start_cond, stop_cond, shifting;

    assign scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
    assign sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    assign scl_rise = scl_s & ~scl_hist_q;
    assign scl_fall = ~scl_s & scl_hist_q;

    // START/STOP require SCL high in both the current and the previous
    // sample, so an SDA change that coincides with an SCL change is treated
    // as an ordinary data edge.
    assign start_cond = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
    assign stop_cond  = scl_s & scl_hist_q & ~sda_hist_q & sda_s;

    assign shifting = (state_q == S_ADDR) || (state_q == S_SUB) || (state_q == S_DATA);

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        full_d     = full_q;
        ptr_d      = ptr_q;
        sda_oe_d   = sda_oe_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        busy_d     = busy_q;

        if (start_cond) begin
            state_d  = S_ADDR;
            cnt_d    = 3'd0;
            full_d   = 1'b0;
            busy_d   = 1'b1;
            sda_oe_d = 1'b0;
        end else if (stop_cond) begin
            // Any partially shifted byte is simply dropped here.
            state_d  = S_IDLE;
            cnt_d    = 3'd0;
            full_d   = 1'b0;
            busy_d   = 1'b0;
            sda_oe_d = 1'b0;
        end else begin
            if (scl_rise && shifting && !full_q) begin
                shift_d = {shift_q[6:0], sda_s};
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    full_d = 1'b1;
                end
            end

            // All sda_oe changes happen on the synchronised SCL falling edge,
            // so the target never moves SDA while SCL is high.
            if (scl_fall) begin
                case (state_q)
                    S_ADDR: begin
                        if (full_q) begin
                            full_d = 1'b0;
                            cnt_d  = 3'd0;
                            if (shift_q[7:1] == DEV_ADDR && !shift_q[0]) begin
                                state_d  = S_ADDR_ACK;
                                sda_oe_d = 1'b1;
                            end else begin
                                state_d = S_IGNORE;
                            end
                        end
                    end
                    S_ADDR_ACK: begin
                        sda_oe_d = 1'b0;
                        state_d  = S_SUB;
                    end
                    S_SUB: begin
                        if (full_q) begin
                            full_d   = 1'b0;
                            cnt_d    = 3'd0;
                            ptr_d    = shift_q;
                            sda_oe_d = 1'b1;
                            state_d  = S_SUB_ACK;
                        end
                    end
                    S_SUB_ACK: begin
                        sda_oe_d = 1'b0;
                        state_d  = S_DATA;
                    end
                    S_DATA: begin
                        if (full_q) begin
                            full_d     = 1'b0;
                            cnt_d      = 3'd0;
                            wr_valid_d = 1'b1;
                            wr_addr_d  = ptr_q;
                            wr_data_d  = shift_q;
                            sda_oe_d   = 1'b1;
                            state_d    = S_DATA_ACK;
                        end
                    end
                    S_DATA_ACK: begin
                        sda_oe_d = 1'b0;
                        ptr_d    = ptr_q + 8'd1;
                        state_d  = S_DATA;
                    end
                    default: begin
                        sda_oe_d = 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // Synchronisers reset to the idle-bus level so release of reset
            // never looks like a START or STOP.
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
            state_q    <= S_IDLE;
            shift_q    <= 8'd0;
            cnt_q      <= 3'd0;
            full_q     <= 1'b0;
            ptr_q      <= 8'd0;
            sda_oe_q   <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= 8'd0;
            wr_data_q  <= 8'd0;
            busy_q     <= 1'b0;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_hist_q <= scl_s;
            sda_hist_q <= sda_s;
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            full_q     <= full_d;
            ptr_q      <= ptr_d;
            sda_oe_q   <= sda_oe_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
        end
    end

    assign sda_out  = 1'b0;
    assign sda_oe   = sda_oe_q;
    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target_wr.sv
// ---------------------------------------------------------------------------
// tb_i2c_target_wr
//
// Directed bench for i2c_target_wr. A behavioural bus master drives SCL and
// SDA (wired-AND with the target's sda_oe). A negedge monitor records write
// strobes and sda_oe activity; each scenario task checks acks, strobes and
// busy against hand-computed values.
// ---------------------------------------------------------------------------
module tb_i2c_target_wr;

    localparam int Q = 4;  // quarter SCL period in clk cycles

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_out, sda_oe, wr_valid, busy;
    logic [7:0] wr_addr, wr_data;

    assign sda_line = sda_m & ~sda_oe;

    i2c_target_wr #(.DEV_ADDR(7'h70), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .scl_in   (scl_m),
        .sda_in   (sda_line),
        .sda_out  (sda_out),
        .sda_oe   (sda_oe),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Monitor state, written only by the monitor process.
    int         nstb      = 0;
    int         oe_cyc    = 0;
    int         oe_glitch = 0;
    int         vld_long  = 0;
    logic       prev_oe   = 1'b0;
    logic       prev_vld  = 1'b0;
    logic [7:0] st_addr [0:15];
    logic [7:0] st_data [0:15];

    always @(negedge clk) begin
        if (wr_valid === 1'b1) begin
            st_addr[nstb[3:0]] = wr_addr;
            st_data[nstb[3:0]] = wr_data;
            nstb = nstb + 1;
            if (prev_vld === 1'b1) vld_long = vld_long + 1;
        end
        if (sda_oe === 1'b1) oe_cyc = oe_cyc + 1;
        if ((sda_oe != prev_oe) && scl_m) oe_glitch = oe_glitch + 1;
        prev_oe  = sda_oe;
        prev_vld = wr_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;
        tick(Q);
        scl_m = 1'b1;
        tick(2 * Q);
        scl_m = 1'b0;
        tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] v, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
        sda_m = 1'b1;
        tick(Q);
        scl_m = 1'b1;
        tick(Q);
        ack = ~sda_line;
        tick(Q);
        scl_m = 1'b0;
        tick(Q);
    endtask

    task automatic bus_start();
        if (!scl_m) begin
            sda_m = 1'b1;
            tick(Q);
            scl_m = 1'b1;
            tick(Q);
        end
        sda_m = 1'b0;
        tick(Q);
        scl_m = 1'b0;
        tick(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0;
        tick(Q);
        scl_m = 1'b1;
        tick(Q);
        sda_m = 1'b1;
        tick(2 * Q);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        total++; if (sda_oe !== 1'b0)   begin bad++; $display("FAIL rst_sda_oe got=%b exp=0", sda_oe); end
        total++; if (sda_out !== 1'b0)  begin bad++; $display("FAIL rst_sda_out got=%b exp=0", sda_out); end
        total++; if (wr_valid !== 1'b0) begin bad++; $display("FAIL rst_wr_valid got=%b exp=0", wr_valid); end
        total++; if (wr_addr !== 8'h00) begin bad++; $display("FAIL rst_wr_addr got=%h exp=00", wr_addr); end
        total++; if (wr_data !== 8'h00) begin bad++; $display("FAIL rst_wr_data got=%h exp=00", wr_data); end
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        rst = 1'b0;
        tick(4);
    endtask

    task automatic test_basic();
        int   base, g0;
        logic a0, a1, a2, a3;
        base = nstb;
        g0   = oe_glitch;
        bus_start();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_start got=%b exp=1", busy); end
        send_byte(8'hE0, a0);
        send_byte(8'h0A, a1);
        send_byte(8'h55, a2);
        send_byte(8'h1F, a3);
        bus_stop();
        tick(4);
        total++; if ({a0, a1, a2, a3} !== 4'b1111) begin bad++; $display("FAIL basic_acks got=%b exp=1111", {a0, a1, a2, a3}); end
        total++; if (nstb - base !== 2) begin bad++; $display("FAIL basic_nstrobe got=%0d exp=2", nstb - base); end
        total++; if (st_addr[base[3:0]] !== 8'h0A) begin bad++; $display("FAIL basic_addr0 got=%h exp=0a", st_addr[base[3:0]]); end
        total++; if (st_data[base[3:0]] !== 8'h55) begin bad++; $display("FAIL basic_data0 got=%h exp=55", st_data[base[3:0]]); end
        base = base + 1;
        total++; if (st_addr[base[3:0]] !== 8'h0B) begin bad++; $display("FAIL basic_addr1 got=%h exp=0b", st_addr[base[3:0]]); end
        total++; if (st_data[base[3:0]] !== 8'h1F) begin bad++; $display("FAIL basic_data1 got=%h exp=1f", st_data[base[3:0]]); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_stop got=%b exp=0", busy); end
        total++; if (oe_glitch - g0 !== 0) begin bad++; $display("FAIL basic_oe_scl_high got=%0d exp=0", oe_glitch - g0); end
        total++; if (vld_long !== 0) begin bad++; $display("FAIL basic_strobe_width got=%0d exp=0", vld_long); end
        total++; if (wr_addr !== 8'h0B || wr_data !== 8'h1F) begin bad++; $display("FAIL basic_hold got=%h/%h exp=0b/1f", wr_addr, wr_data); end
    endtask

    task automatic test_wrong_addr();
        int   base, oe0;
        logic a0, a1, a2;
        base = nstb;
        oe0  = oe_cyc;
        bus_start();
        send_byte(8'hE2, a0);
        send_byte(8'h0A, a1);
        send_byte(8'h55, a2);
        bus_stop();
        tick(4);
        total++; if (a0 !== 1'b0) begin bad++; $display("FAIL wrong_addr_ack got=%b exp=0", a0); end
        total++; if ({a1, a2} !== 2'b00) begin bad++; $display("FAIL wrong_addr_later_acks got=%b exp=00", {a1, a2}); end
        total++; if (oe_cyc - oe0 !== 0) begin bad++; $display("FAIL wrong_addr_oe got=%0d exp=0", oe_cyc - oe0); end
        total++; if (nstb - base !== 0) begin bad++; $display("FAIL wrong_addr_strobes got=%0d exp=0", nstb - base); end
    endtask

    task automatic test_read();
        int   base, oe0;
        logic a0;
        base = nstb;
        oe0  = oe_cyc;
        bus_start();
        send_byte(8'hE1, a0);
        bus_stop();
        tick(4);
        total++; if (a0 !== 1'b0) begin bad++; $display("FAIL read_ack got=%b exp=0", a0); end
        total++; if (oe_cyc - oe0 !== 0) begin bad++; $display("FAIL read_oe got=%0d exp=0", oe_cyc - oe0); end
        total++; if (nstb - base !== 0) begin bad++; $display("FAIL read_strobes got=%0d exp=0", nstb - base); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL read_busy got=%b exp=0", busy); end
    endtask

    task automatic test_wrap();
        int   base;
        logic a0, a1, a2, a3;
        base = nstb;
        bus_start();
        send_byte(8'hE0, a0);
        send_byte(8'hFF, a1);
        send_byte(8'h11, a2);
        send_byte(8'h22, a3);
        bus_stop();
        tick(4);
        total++; if ({a0, a1, a2, a3} !== 4'b1111) begin bad++; $display("FAIL wrap_acks got=%b exp=1111", {a0, a1, a2, a3}); end
        total++; if (nstb - base !== 2) begin bad++; $display("FAIL wrap_nstrobe got=%0d exp=2", nstb - base); end
        total++; if (st_addr[base[3:0]] !== 8'hFF || st_data[base[3:0]] !== 8'h11) begin bad++; $display("FAIL wrap_strobe0 got=%h/%h exp=ff/11", st_addr[base[3:0]], st_data[base[3:0]]); end
        base = base + 1;
        total++; if (st_addr[base[3:0]] !== 8'h00 || st_data[base[3:0]] !== 8'h22) begin bad++; $display("FAIL wrap_strobe1 got=%h/%h exp=00/22", st_addr[base[3:0]], st_data[base[3:0]]); end
    endtask

    task automatic test_rep_start();
        int   base;
        logic a0, a1, a2, a3, a4;
        base = nstb;
        bus_start();
        send_byte(8'hE0, a0);
        send_byte(8'h05, a1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        bus_start();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rep_busy got=%b exp=1", busy); end
        send_byte(8'hE0, a2);
        send_byte(8'h20, a3);
        send_byte(8'h77, a4);
        bus_stop();
        tick(4);
        total++; if ({a0, a1, a2, a3, a4} !== 5'b11111) begin bad++; $display("FAIL rep_acks got=%b exp=11111", {a0, a1, a2, a3, a4}); end
        total++; if (nstb - base !== 1) begin bad++; $display("FAIL rep_nstrobe got=%0d exp=1", nstb - base); end
        total++; if (st_addr[base[3:0]] !== 8'h20 || st_data[base[3:0]] !== 8'h77) begin bad++; $display("FAIL rep_strobe got=%h/%h exp=20/77", st_addr[base[3:0]], st_data[base[3:0]]); end
    endtask

    task automatic test_reset_mid();
        int   base;
        logic a0, a1;
        base = nstb;
        bus_start();
        send_byte(8'hE0, a0);
        send_byte(8'h0A, a1);
        send_bit(1'b0);
        send_bit(1'b1);
        sda_m = 1'b0;
        tick(Q);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rmid_busy_before got=%b exp=1", busy); end
        rst = 1'b1;
        #2;
        total++; if (busy !== 1'b0 || sda_oe !== 1'b0 || wr_valid !== 1'b0) begin bad++; $display("FAIL rmid_async got=%b%b%b exp=000", busy, sda_oe, wr_valid); end
        scl_m = 1'b1;
        sda_m = 1'b1;
        tick(4);
        rst = 1'b0;
        tick(4);
        total++; if (nstb - base !== 0) begin bad++; $display("FAIL rmid_strobes got=%0d exp=0", nstb - base); end
        test_basic();
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_wrong_addr();
        test_read();
        test_wrap();
        test_rep_start();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_target_wr.md
Name: i2c_target_wr

Overview:
- I2C target (slave) receiver for the dice design; the responding end of the bus master that drives uio[2] (SDA) and uio[3] (SCL).
- Samples SCL/SDA in the system clock domain, decodes START/STOP, and matches a 7-bit device address.
- ACKs write transactions, captures a sub-address byte, and emits one register-write strobe per following data byte, auto-incrementing the sub-address.
- Write-only; read requests are NAKed.

Parameters:
- DEV_ADDR, 7'h70, 7-bit target address (bus byte 8'hE0 for write).
- SYNC_STAGES, 2, synchroniser flops on scl_in/sda_in before edge detection (min 2).

Ports:
- clk  in  1  system clock; must be at least 8x the SCL rate.
- rst  in  1  asynchronous reset, active-high.
- scl_in  in  1  raw SCL from pad (uio_in[3]).
- sda_in  in  1  raw SDA from pad (uio_in[2]).
- sda_out  out  1  constant 0 (open-drain emulation).
- sda_oe  out  1  1 = pull SDA low (ACK); drives uio_oe[2].
- wr_valid  out  1  one-cycle write strobe.
- wr_addr  out  8  register address for the current strobe.
- wr_data  out  8  register data for the current strobe.
- busy  out  1  high from START until STOP.

Behaviour:
- Reset (async): all outputs 0; state IDLE; shift register, bit counter and address pointer cleared; synchroniser flops set to 1 (idle bus).
- Input conditioning: each line passes through SYNC_STAGES flops plus one history flop. All decisions use the synchronised levels; edges are detected by comparing against the history flop.
- START: SDA falls while SCL is high. Legal in any state, including repeated START mid-byte. Action: enter ADDR, clear the bit counter, set busy=1, release sda_oe.
- STOP: SDA rises while SCL is high. Legal in any state. Action: enter IDLE, set busy=0, release sda_oe. A partial byte is discarded and produces no strobe.
- Data bits: sampled MSB first on the SCL rising edge. The bit counter counts 0..7.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits. On the SCL falling edge after bit 8:
    - if byte[7:1]==DEV_ADDR and byte[0]==0 -> ADDR_ACK, sda_oe=1;
    - otherwise (address mismatch, or match with R/W=1) -> IGNORE, sda_oe stays 0 (NAK).
  - ADDR_ACK: hold sda_oe=1 through the ACK clock. On the next SCL falling edge release sda_oe and go to SUB.
  - SUB: shift 8 bits. On the falling edge after bit 8, load the pointer with the byte, set sda_oe=1, go to SUB_ACK.
  - SUB_ACK: same as ADDR_ACK, then go to DATA.
  - DATA: shift 8 bits. On the falling edge after bit 8:
    - wr_valid=1 for exactly one clk;
    - wr_addr = pointer, wr_data = byte;
    - set sda_oe=1 and go to DATA_ACK.
  - DATA_ACK: on the next SCL falling edge release sda_oe, increment the pointer mod 256 (8'hFF -> 8'h00), and return to DATA.
  - IGNORE: sda_oe=0; leave only on START or STOP.
- wr_addr/wr_data hold their last values between strobes.
- Latency: wr_valid asserts SYNC_STAGES+1 clk after the raw SCL falling edge that ends bit 8.
- sda_oe changes only on synchronised SCL falling edges, never while SCL is high, so the block cannot create a false START/STOP.
- Simultaneous SCL and SDA change within one sample: treat as a data-bit edge, not START/STOP.
- A transaction with no data byte (START, addr, sub, STOP) produces no strobe and leaves the pointer loaded.

Test Plan:
1. START, 8'hE0, 8'h0A, 8'h55, 8'h1F, STOP.
   - Required: ACK on all four bytes.
   - Exactly two strobes: (wr_addr 8'h0A, wr_data 8'h55), then (8'h0B, 8'h1F).
   - busy falls after STOP.
2. START, 8'hE2 (wrong address), 8'h0A, 8'h55, STOP.
   - Required: SDA high at the first ACK slot, sda_oe never 1, no wr_valid.
3. START, 8'hE1 (read request), STOP.
   - Required: NAK, no strobe, state IDLE afterwards.
4. START, 8'hE0, 8'hFF, 8'h11, 8'h22, STOP.
   - Required: strobes (8'hFF, 8'h11) and (8'h00, 8'h22), confirming pointer wrap.
5. START, 8'hE0, 8'h05, 4 bits of data, repeated START, 8'hE0, 8'h20, 8'h77, STOP.
   - Required: the partial byte gives no strobe; exactly one strobe (8'h20, 8'h77).
6. Assert rst during bit 3 of the data byte in scenario 1.
   - Required: sda_oe/busy/wr_valid go to 0 immediately.
   - The following clean transaction from scenario 1 completes correctly.
